gf_mult_seq_ctrl: RTL and testbench
===================================

Name: gf_mult_seq_ctrl

Overview:
Sequencer for the serial-in / parallel GF multiply / serial-out datapath. The block sits beside the input shift registers, the carry-less multiplier and the output serializer. For each operation it:
- enables DATA_WIDTH input shift cycles,
- holds the multiplier enable for its compute latency,
- loads the 2*DATA_WIDTH-bit product into the output serializer,
- enables 2*DATA_WIDTH output shift cycles.
A host drives the block with a start/busy/done handshake.

Parameters:
DATA_WIDTH, 8, operand width in bits; the product is 2*DATA_WIDTH bits.
MULT_LATENCY, 1, number of cycles mult_enable is held before capture (>=1).
CNT_W, $clog2(2*DATA_WIDTH+MULT_LATENCY+1), width of the internal phase counter.

Ports:
clk  input  1  rising-edge clock
resetn  input  1  synchronous active-low reset
start  input  1  begin operation; sampled only in IDLE or DONE
abort  input  1  cancel operation; has priority over start
busy  output  1  high in every state except IDLE
in_shift_en  output  1  shift enable for both operand input registers
mult_enable  output  1  multiplier enable
out_load  output  1  parallel load of the output serializer
out_shift_en  output  1  output serializer shift enable
out_valid  output  1  the serial output bit is valid this cycle
done  output  1  one-cycle completion pulse
phase_cnt  output  CNT_W  cycles elapsed in the current state, for debug

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-low on resetn.
- Outputs: all outputs are registered and decoded from the state register.
- Reset (resetn=0 at an edge): state=IDLE and phase_cnt=0. busy, in_shift_en, mult_enable, out_load, out_shift_en, out_valid and done are all 0. Reset mid-operation discards the operation and produces no done.
- States and transitions:
  - IDLE: all strobes 0. If start=1 and abort=0, go to LOAD_IN.
  - LOAD_IN: in_shift_en=1 for exactly DATA_WIDTH cycles, then go to COMPUTE.
  - COMPUTE: mult_enable=1 for exactly MULT_LATENCY cycles, then go to CAPTURE.
  - CAPTURE: out_load=1 for 1 cycle, then go to SHIFT_OUT.
  - SHIFT_OUT: out_shift_en=1 and out_valid=1 for exactly 2*DATA_WIDTH cycles, then go to DONE.
  - DONE: done=1 and busy=1 for 1 cycle. If start=1, go directly to LOAD_IN (back-to-back operation with no IDLE cycle); otherwise go to IDLE.
- Strobe exclusivity: at most one of in_shift_en, mult_enable, out_load and out_shift_en is high in any cycle.
- phase_cnt: resets to 0 on every state entry and increments each cycle within a state. A state exits when phase_cnt equals its length minus 1. phase_cnt never wraps.
- start rules: start in LOAD_IN through SHIFT_OUT is ignored and not queued. start held high continuously produces back-to-back operations through DONE.
- abort rules: abort=1 in any non-IDLE state moves the block to IDLE at the next edge, and all strobes are 0 from that edge. No done is produced. abort in IDLE has no effect. When start and abort are both high in IDLE or DONE, the block goes to IDLE.
- Timing: let the start-sampling edge be E0 and cycle k the cycle after edge E0+k.
  - in_shift_en: cycles 1..DW.
  - mult_enable: cycles DW+1..DW+ML.
  - out_load: cycle DW+ML+1.
  - out_valid: cycles DW+ML+2..3DW+ML+1.
  - done: cycle 3DW+ML+2.
  - busy is high from cycle 1 through the done cycle.

Optional Feature:
GF_SEQ_OPCOUNT_EN
- Defined: adds output op_count (16 bits). It resets to 0 and increments on every done pulse, saturating at 16'hFFFF. Aborted operations are not counted.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
1. DW=8, ML=1: start pulse at E0 -> in_shift_en cycles 1-8, mult_enable cycle 9, out_load cycle 10, out_valid cycles 11-26, done cycle 27, busy 0 at cycle 28.
2. start held high for 60 cycles -> done at cycles 27 and 54; the second in_shift_en run starts at cycle 28; busy never drops between operations.
3. Pulse start again at cycle 5 of an operation -> ignored; exactly one done, at cycle 27.
4. abort at cycle 12 (SHIFT_OUT) -> all strobes 0 and busy 0 from cycle 13; no done; a new start at cycle 15 produces done at cycle 15+27.
5. resetn=0 at cycle 9 for 1 cycle -> next cycle all outputs 0, phase_cnt=0, state IDLE; start and abort asserted together in IDLE -> stays IDLE.
6. With GF_SEQ_OPCOUNT_EN: 3 completed operations plus 1 aborted operation -> op_count=3; force the count to 16'hFFFF and complete one more operation -> stays 16'hFFFF.

Source files
------------

// File: rtl/gf_mult_seq_ctrl.sv
// Sequencer for the serial-in / GF multiply / serial-out datapath: input shift, compute, capture, output shift.
// Optional macro GF_SEQ_OPCOUNT_EN adds a saturating 16-bit count of completed operations (op_count).
module gf_mult_seq_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int MULT_LATENCY = 1,
  parameter int CNT_W        = $clog2(2*DATA_WIDTH+MULT_LATENCY+1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             in_shift_en,
  output logic             mult_enable,
  output logic             out_load,
  output logic             out_shift_en,
  output logic             out_valid,
  output logic             done,
  output logic [CNT_W-1:0] phase_cnt
`ifdef GF_SEQ_OPCOUNT_EN
  ,
  output logic [15:0]      op_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_IN,
    S_COMPUTE,
    S_CAPTURE,
    S_SHIFT_OUT,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LOAD_LAST    = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] COMPUTE_LAST = CNT_W'(MULT_LATENCY - 1);
  localparam logic [CNT_W-1:0] SHIFT_LAST   = CNT_W'(2*DATA_WIDTH - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] phase_cnt_reg;
  logic             busy_reg, in_shift_en_reg, mult_enable_reg, out_load_reg;
  logic             out_shift_en_reg, out_valid_reg, done_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:      if (start && !abort) state_next = S_LOAD_IN;
      S_LOAD_IN:   if (phase_cnt_reg == LOAD_LAST) state_next = S_COMPUTE;
      S_COMPUTE:   if (phase_cnt_reg == COMPUTE_LAST) state_next = S_CAPTURE;
      S_CAPTURE:   state_next = S_SHIFT_OUT;
      S_SHIFT_OUT: if (phase_cnt_reg == SHIFT_LAST) state_next = S_DONE;
      S_DONE:      state_next = (start && !abort) ? S_LOAD_IN : S_IDLE;
      default:     state_next = S_IDLE;
    endcase
    // Abort overrides everything, including a back-to-back start sampled in DONE.
    if (abort && (state_reg != S_IDLE)) state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg     <= S_IDLE;
      phase_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if ((state_next != state_reg) || (state_next == S_IDLE)) begin
        phase_cnt_reg <= '0;
      end else begin
        phase_cnt_reg <= phase_cnt_reg + 1'b1;
      end
    end
  end

  // Strobes are registered from the next state so they line up with state_reg.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy_reg         <= 1'b0;
      in_shift_en_reg  <= 1'b0;
      mult_enable_reg  <= 1'b0;
      out_load_reg     <= 1'b0;
      out_shift_en_reg <= 1'b0;
      out_valid_reg    <= 1'b0;
      done_reg         <= 1'b0;
    end else begin
      busy_reg         <= (state_next != S_IDLE);
      in_shift_en_reg  <= (state_next == S_LOAD_IN);
      mult_enable_reg  <= (state_next == S_COMPUTE);
      out_load_reg     <= (state_next == S_CAPTURE);
      out_shift_en_reg <= (state_next == S_SHIFT_OUT);
      out_valid_reg    <= (state_next == S_SHIFT_OUT);
      done_reg         <= (state_next == S_DONE);
    end
  end

  assign busy         = busy_reg;
  assign in_shift_en  = in_shift_en_reg;
  assign mult_enable  = mult_enable_reg;
  assign out_load     = out_load_reg;
  assign out_shift_en = out_shift_en_reg;
  assign out_valid    = out_valid_reg;
  assign done         = done_reg;
  assign phase_cnt    = phase_cnt_reg;

`ifdef GF_SEQ_OPCOUNT_EN
  logic [15:0] op_count_reg;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      op_count_reg <= '0;
    end else if (done_reg && (op_count_reg != 16'hFFFF)) begin
      op_count_reg <= op_count_reg + 16'd1;
    end
  end

  assign op_count = op_count_reg;
`endif

endmodule

// File: tb/tb_gf_mult_seq_ctrl.sv
// Directed self-checking bench for gf_mult_seq_ctrl with DATA_WIDTH=8, MULT_LATENCY=1.
// Build with GF_SEQ_OPCOUNT_EN defined to also exercise op_count.
module tb_gf_mult_seq_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic       abort;
  logic       busy, in_shift_en, mult_enable, out_load, out_shift_en, out_valid, done;
  logic [4:0] phase_cnt;
`ifdef GF_SEQ_OPCOUNT_EN
  logic [15:0] op_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gf_mult_seq_ctrl #(.DATA_WIDTH(8), .MULT_LATENCY(1)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .abort        (abort),
    .busy         (busy),
    .in_shift_en  (in_shift_en),
    .mult_enable  (mult_enable),
    .out_load     (out_load),
    .out_shift_en (out_shift_en),
    .out_valid    (out_valid),
    .done         (done),
    .phase_cnt    (phase_cnt)
`ifdef GF_SEQ_OPCOUNT_EN
    ,
    .op_count     (op_count)
`endif
  );

  // {busy, in_shift_en, mult_enable, out_load, out_shift_en, out_valid, done}
  logic [6:0] obs;
  assign obs = {busy, in_shift_en, mult_enable, out_load, out_shift_en, out_valid, done};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hand-derived timing for DW=8, ML=1 with start driven in cycle 0.
  function automatic logic [6:0] exp_vec(input int k);
    if (k >= 1 && k <= 8)   return 7'b1100000;
    if (k == 9)             return 7'b1010000;
    if (k == 10)            return 7'b1001000;
    if (k >= 11 && k <= 26) return 7'b1000110;
    if (k == 27)            return 7'b1000001;
    return 7'b0000000;
  endfunction

  int done_cnt;

  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    step();
    step();
    check("reset outputs", 32'(obs), 32'h0);
    check("reset phase", 32'(phase_cnt), 32'h0);
    resetn = 1'b1;
    step();
    check("idle after reset", 32'(obs), 32'h0);

    // 1: single operation
    start = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 1) start = 1'b0;
      check($sformatf("t1 k=%0d", k), 32'(obs), 32'(exp_vec(k)));
      if (k == 1)  check("t1 phase k=1", 32'(phase_cnt), 32'd0);
      if (k == 8)  check("t1 phase k=8", 32'(phase_cnt), 32'd7);
      if (k == 11) check("t1 phase k=11", 32'(phase_cnt), 32'd0);
      if (k == 26) check("t1 phase k=26", 32'(phase_cnt), 32'd15);
    end
    $display("test1 single op: total=%0d bad=%0d", total, bad);

    // 2: start held high -> back-to-back operations, period 27
    start = 1'b1;
    done_cnt = 0;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (k == 60) start = 1'b0;
      if (done) done_cnt++;
      check($sformatf("t2 k=%0d", k), 32'(obs), 32'(exp_vec(((k - 1) % 27) + 1)));
    end
    check("t2 done count", 32'(done_cnt), 32'd2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t2 abort in LOAD_IN", 32'(obs), 32'h0);
    step();
    $display("test2 back-to-back: total=%0d bad=%0d", total, bad);

    // 3: start pulsed mid-operation is ignored
    start = 1'b1;
    done_cnt = 0;
    for (int k = 1; k <= 32; k++) begin
      step();
      start = (k == 5);
      if (done) done_cnt++;
      check($sformatf("t3 k=%0d", k), 32'(obs), 32'(exp_vec(k)));
    end
    check("t3 done count", 32'(done_cnt), 32'd1);
    $display("test3 ignored start: total=%0d bad=%0d", total, bad);

    // 4: abort in SHIFT_OUT, then restart at cycle 15
    start = 1'b1;
    done_cnt = 0;
    for (int k = 1; k <= 45; k++) begin
      step();
      if (done) done_cnt++;
      if (k <= 12)      check($sformatf("t4 k=%0d", k), 32'(obs), 32'(exp_vec(k)));
      else if (k <= 15) check($sformatf("t4 k=%0d", k), 32'(obs), 32'h0);
      else              check($sformatf("t4 k=%0d", k), 32'(obs), 32'(exp_vec(k - 15)));
      start = (k == 15);
      abort = (k == 12);
    end
    check("t4 done count", 32'(done_cnt), 32'd1);
    $display("test4 abort/restart: total=%0d bad=%0d", total, bad);

    // 5: reset mid-operation; start+abort in IDLE; start+abort in DONE
    start = 1'b1;
    done_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 1) start = 1'b0;
      if (done) done_cnt++;
      if (k <= 9) check($sformatf("t5 k=%0d", k), 32'(obs), 32'(exp_vec(k)));
      else begin
        check($sformatf("t5 post-reset k=%0d", k), 32'(obs), 32'h0);
        check($sformatf("t5 post-reset phase k=%0d", k), 32'(phase_cnt), 32'h0);
      end
      resetn = (k != 9);
    end
    check("t5 no done after reset", 32'(done_cnt), 32'd0);
    start = 1'b1;
    abort = 1'b1;
    step();
    check("t5 start+abort idle 1", 32'(obs), 32'h0);
    step();
    check("t5 start+abort idle 2", 32'(obs), 32'h0);
    abort = 1'b0;
    for (int k = 1; k <= 29; k++) begin
      step();
      if (k <= 27) check($sformatf("t5b k=%0d", k), 32'(obs), 32'(exp_vec(k)));
      else         check($sformatf("t5b k=%0d", k), 32'(obs), 32'h0);
      start = (k == 27);
      abort = (k == 27);
    end
    start = 1'b0;
    abort = 1'b0;
    $display("test5 reset/start+abort: total=%0d bad=%0d", total, bad);

`ifdef GF_SEQ_OPCOUNT_EN
    // 6: op_count counts completions only and saturates
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    check("t6 count reset", 32'(op_count), 32'd0);
    for (int n = 0; n < 3; n++) begin
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (28) step();
    end
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    repeat (3) step();
    check("t6 count after 3+abort", 32'(op_count), 32'd3);
    force dut.op_count_reg = 16'hFFFF;
    step();
    release dut.op_count_reg;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (28) step();
    check("t6 count saturates", 32'(op_count), 32'hFFFF);
    $display("test6 op_count: total=%0d bad=%0d", total, bad);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Independent watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
